// File: rtl/smc_step_scheduler.sv
// Control-period scheduler for the SMC loop: sample tick, sensor acquisition, one nominal-model
// step with held input, then publication of the saturated tracking error.
module smc_step_scheduler #(
    parameter int unsigned PERIOD_CYCLES = 5000,
    parameter int unsigned ACQ_TIMEOUT   = 64,
    parameter int unsigned SETTLE_CYCLES = 2    // must be at least 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sens_valid,
    output logic        sens_ready,
    input  logic [31:0] sens_theta,
    input  logic [31:0] u_in,
    input  logic        u_valid,
    output logic [31:0] u_t,
    output logic        model_step,
    input  logic [31:0] model_u,
    input  logic [31:0] model_udot,
    output logic [31:0] err,
    output logic [31:0] err_dot,
    output logic        out_valid,
    output logic        stale,
    output logic        overrun,
    output logic [7:0]  overrun_cnt
);

    localparam int unsigned PW      = $clog2(PERIOD_CYCLES);
    localparam int unsigned SEQ_MAX = (ACQ_TIMEOUT > SETTLE_CYCLES) ? ACQ_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CW      = $clog2(SEQ_MAX + 1) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StAcquire,
        StStep,
        StSettle,
        StPublish
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [31:0]   theta_q, theta_d;
    logic [31:0]   u_pend_q, u_pend_d;
    logic [31:0]   u_t_q, u_t_d;
    logic [31:0]   err_q, err_d;
    logic [31:0]   err_dot_q, err_dot_d;
    logic          stale_q, stale_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    overrun_cnt_q, overrun_cnt_d;
    logic          sens_ready_q, sens_ready_d;
    logic          model_step_q, model_step_d;
    logic          out_valid_q, out_valid_d;
    logic          tick;
    logic [32:0]   diff;
    logic [31:0]   err_sat;

    // 33-bit difference so that the sign of the true result survives before clamping.
    always_comb begin
        diff = {model_u[31], model_u} - {theta_q[31], theta_q};
        if (diff[32] != diff[31]) begin
            err_sat = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            err_sat = diff[31:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q + 1'b1;
        theta_d       = theta_q;
        u_pend_d      = u_valid ? u_in : u_pend_q;
        u_t_d         = u_t_q;
        err_d         = err_q;
        err_dot_d     = err_dot_q;
        stale_d       = stale_q;
        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;

        tick = (state_q != StIdle) && (period_q == PW'(PERIOD_CYCLES - 1));
        if ((state_q == StIdle) || !enable || tick) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end

        // Ticks that land mid-sequence are dropped and only counted.
        if (tick && (state_q != StWaitTick)) begin
            overrun_d = 1'b1;
            if (overrun_cnt_q != 8'hFF) begin
                overrun_cnt_d = overrun_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWaitTick;
                end
            end
            StWaitTick: begin
                if (tick) begin
                    state_d = StAcquire;
                    cyc_d   = '0;
                end
            end
            StAcquire: begin
                if (sens_valid) begin
                    theta_d = sens_theta;
                    stale_d = 1'b0;
                    state_d = StStep;
                end else if (cyc_q == CW'(ACQ_TIMEOUT)) begin
                    stale_d = 1'b1;
                    state_d = StStep;
                end
            end
            StStep: begin
                u_t_d   = u_pend_q;
                state_d = StSettle;
                cyc_d   = '0;
            end
            StSettle: begin
                if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = StPublish;
                    if (enable) begin
                        err_d     = err_sat;
                        err_dot_d = model_udot;
                    end
                end
            end
            StPublish: begin
                state_d = StWaitTick;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!enable) begin
            state_d = StIdle;
        end

        // Strobes are registered decodes of the next state.
        sens_ready_d = (state_d == StAcquire);
        model_step_d = (state_d == StStep);
        out_valid_d  = (state_d == StPublish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            period_q      <= '0;
            cyc_q         <= '0;
            theta_q       <= '0;
            u_pend_q      <= '0;
            u_t_q         <= '0;
            err_q         <= '0;
            err_dot_q     <= '0;
            stale_q       <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
            sens_ready_q  <= 1'b0;
            model_step_q  <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            cyc_q         <= cyc_d;
            theta_q       <= theta_d;
            u_pend_q      <= u_pend_d;
            u_t_q         <= u_t_d;
            err_q         <= err_d;
            err_dot_q     <= err_dot_d;
            stale_q       <= stale_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
            sens_ready_q  <= sens_ready_d;
            model_step_q  <= model_step_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign sens_ready  = sens_ready_q;
    assign model_step  = model_step_q;
    assign out_valid   = out_valid_q;
    assign u_t         = u_t_q;
    assign err         = err_q;
    assign err_dot     = err_dot_q;
    assign stale       = stale_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_smc_step_scheduler.sv
// Bench for smc_step_scheduler: table vectors, randomized sequences against a transaction-level
// model, enable-drop and reset corner cases, and an overrun run on a short-period instance.
module tb_smc_step_scheduler;

    localparam int P  = 100;
    localparam int T  = 64;
    localparam int S  = 2;
    localparam int P2 = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        en2 = 1'b0;
    logic        sens_valid = 1'b0;
    logic        sens_valid2 = 1'b0;
    logic        u_valid = 1'b0;
    logic [31:0] sens_theta = '0;
    logic [31:0] u_in = '0;
    logic [31:0] model_u = '0;
    logic [31:0] model_udot = '0;

    logic        sens_ready, model_step, out_valid, stale, overrun;
    logic [31:0] u_t, err, err_dot;
    logic [7:0]  overrun_cnt;
    logic        sens_ready2, model_step2, out_valid2, stale2, overrun2;
    logic [31:0] u_t2, err2, err_dot2;
    logic [7:0]  overrun_cnt2;

    smc_step_scheduler #(.PERIOD_CYCLES(P), .ACQ_TIMEOUT(T), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sens_valid(sens_valid),
        .sens_ready(sens_ready), .sens_theta(sens_theta), .u_in(u_in), .u_valid(u_valid),
        .u_t(u_t), .model_step(model_step), .model_u(model_u), .model_udot(model_udot),
        .err(err), .err_dot(err_dot), .out_valid(out_valid), .stale(stale),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    smc_step_scheduler #(.PERIOD_CYCLES(P2), .ACQ_TIMEOUT(T), .SETTLE_CYCLES(S)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .sens_valid(sens_valid2),
        .sens_ready(sens_ready2), .sens_theta(sens_theta), .u_in(u_in), .u_valid(u_valid),
        .u_t(u_t2), .model_step(model_step2), .model_u(model_u), .model_udot(model_udot),
        .err(err2), .err_dot(err_dot2), .out_valid(out_valid2), .stale(stale2),
        .overrun(overrun2), .overrun_cnt(overrun_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          d;        // cycles after ACQUIRE entry that the sample arrives; > T = silent
        logic [31:0] th;
        logic [31:0] mu;
        logic [31:0] mud;
        int          umode;    // 0 random u pulses, 1 directed pulses, 2 none
        logic [31:0] exp_err;
        logic        exp_stale;
        logic [31:0] exp_ut;
        logic        chk_ut;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] theta_m = '0;
    logic [31:0] last_u = '0;
    logic [31:0] ut_m = '0;
    logic [31:0] err_m = '0;
    logic        stale_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_strobes(input string name, input logic r, input logic st, input logic v);
        chk(name, {29'd0, sens_ready, model_step, out_valid}, {29'd0, r, st, v});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        longint da, db, dd;
        da = $signed(a);
        db = $signed(b);
        dd = da - db;
        if (dd > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (dd < -64'sd2147483648) return 32'h8000_0000;
        return dd[31:0];
    endfunction

    function automatic vec_t mk(input int d, input logic [31:0] th, input logic [31:0] mu,
                                input logic [31:0] mud, input int umode, input logic [31:0] ee,
                                input logic es, input logic [31:0] eu, input logic cu);
        vec_t v;
        v.d = d; v.th = th; v.mu = mu; v.mud = mud; v.umode = umode;
        v.exp_err = ee; v.exp_stale = es; v.exp_ut = eu; v.chk_ut = cu;
        return v;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h7FFF_FFFF - $urandom_range(0, 255);
            1: r = 32'h8000_0000 + $urandom_range(0, 255);
            default: r = $urandom();
        endcase
        return r;
    endfunction

    // Called in IDLE; raises enable and expects ACQUIRE exactly P cycles after WAIT_TICK entry.
    task automatic start_loop();
        chk_strobes("idle_strobes", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        enable = 1'b1;
        sens_valid = 1'b0;
        u_valid = 1'b0;
        for (int i = 1; i <= P; i++) begin
            next_cycle();
            chk_strobes("wait_tick_strobes", 1'b0, 1'b0, 1'b0);
        end
        next_cycle();
    endtask

    // Entered in the first ACQUIRE cycle; runs one full period and leaves at the next ACQUIRE.
    task automatic run_seq(input vec_t v, input int drop_at, input logic use_tab);
        int   s, pub;
        logic hs_ok, alive;
        hs_ok = (v.d <= T);
        s = hs_ok ? v.d + 1 : T + 1;
        pub = s + S + 1;
        for (int k = 0; k < P; k++) begin
            alive = (drop_at < 0) || (k <= drop_at);
            chk_strobes("seq_strobes", alive && (k < s), alive && (k == s), alive && (k == pub));
            if (k == s && alive) begin
                if (hs_ok) begin
                    theta_m = v.th;
                    stale_m = 1'b0;
                end else begin
                    stale_m = 1'b1;
                end
                ut_m = last_u;
            end
            if (k == pub && alive) begin
                err_m = sat_sub(v.mu, theta_m);
                chk("err", err, err_m);
                chk("err_dot", err_dot, v.mud);
                chk("stale", 32'(stale), 32'(stale_m));
                chk("u_t", u_t, ut_m);
                if (use_tab) begin
                    chk("tab_err", err, v.exp_err);
                    chk("tab_stale", 32'(stale), 32'(v.exp_stale));
                    if (v.chk_ut) chk("tab_u_t", u_t, v.exp_ut);
                end
            end
            if (k == P - 1) begin
                chk("err_hold", err, err_m);
                chk("no_overrun", {23'd0, overrun, overrun_cnt}, 32'd0);
            end
            if (k == drop_at) enable = 1'b0;
            sens_valid = hs_ok && (k == v.d);
            sens_theta = sens_valid ? v.th : $urandom();
            model_u = v.mu;
            model_udot = v.mud;
            u_valid = 1'b0;
            if (v.umode == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    u_valid = 1'b1;
                    u_in = $urandom();
                end
            end else if (v.umode == 1) begin
                if (k == 1) begin u_valid = 1'b1; u_in = 32'h200; end
                if (k == 3) begin u_valid = 1'b1; u_in = 32'h300; end
                if (k == s) begin u_valid = 1'b1; u_in = 32'h777; end
            end
            if (u_valid) last_u = u_in;
            next_cycle();
        end
        u_valid = 1'b0;
        sens_valid = 1'b0;
    endtask

    vec_t tab[10];
    vec_t rv;

    initial begin
        tab[0] = mk(0,     32'h400,       32'hC00,       32'h11, 2, 32'h800,       1'b0, 32'h0,   1'b1);
        tab[1] = mk(3,     32'h1000,      32'h800,       32'h22, 2, 32'hFFFF_F800, 1'b0, 32'h0,   1'b0);
        tab[2] = mk(T + 3, 32'hDEAD,      32'h2000,      32'h33, 2, 32'h1000,      1'b1, 32'h0,   1'b0);
        tab[3] = mk(T,     32'h10,        32'h10,        32'h44, 2, 32'h0,         1'b0, 32'h0,   1'b0);
        tab[4] = mk(1,     32'h8000_0100, 32'h7FFF_FF00, 32'h55, 2, 32'h7FFF_FFFF, 1'b0, 32'h0,   1'b0);
        tab[5] = mk(2,     32'h7FFF_FF00, 32'h8000_0100, 32'h66, 2, 32'h8000_0000, 1'b0, 32'h0,   1'b0);
        tab[6] = mk(5,     32'h0,         32'h5,         32'h77, 1, 32'h5,         1'b0, 32'h300, 1'b1);
        tab[7] = mk(0,     32'h400,       32'hC00,       32'h88, 2, 32'h800,       1'b0, 32'h777, 1'b1);
        tab[8] = mk(T + 1, 32'h99,        32'h10,        32'h99, 2, 32'hFFFF_FC10, 1'b1, 32'h777, 1'b1);
        tab[9] = mk(0,     32'h1,         32'h0,         32'hAA, 2, 32'hFFFF_FFFF, 1'b0, 32'h777, 1'b1);

        // Reset state of both instances.
        next_cycle();
        next_cycle();
        chk("rst_outputs", {28'd0, sens_ready, model_step, out_valid, stale}, 32'd0);
        chk("rst_u_t", u_t, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_err_dot", err_dot, 32'd0);
        chk("rst_overrun", {23'd0, overrun, overrun_cnt}, 32'd0);
        chk("rst_dut2", {23'd0, overrun2, overrun_cnt2} | 32'(out_valid2), 32'd0);

        start_loop();
        for (int i = 0; i < 10; i++) run_seq(tab[i], -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rv = mk($urandom_range(0, T + 5), rnd32(), rnd32(), $urandom(), 0, 32'h0, 1'b0,
                    32'h0, 1'b0);
            run_seq(rv, -1, 1'b0);
        end

        // Enable falls in the first SETTLE cycle: no publish, outputs hold, loop restarts cleanly.
        rv = mk(0, 32'h123, 32'h456, 32'hBB, 2, 32'h0, 1'b0, 32'h0, 1'b0);
        run_seq(rv, 2, 1'b0);
        start_loop();

        // Reset asserted mid-ACQUIRE with a silent sensor.
        sens_valid = 1'b0;
        model_u = 32'h1234;
        chk_strobes("acq_before_rst", 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        chk_strobes("acq_before_rst2", 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {28'd0, sens_ready, model_step, out_valid, stale}, 32'd0);
        chk("rst_mid_u_t", u_t, 32'd0);
        chk("rst_mid_err", err, 32'd0);
        chk("rst_mid_err_dot", err_dot, 32'd0);
        theta_m = '0; last_u = '0; ut_m = '0; err_m = '0; stale_m = 1'b0;
        repeat (3) next_cycle();
        chk_strobes("in_reset", 1'b0, 1'b0, 1'b0);
        start_loop();
        run_seq(mk(T + 2, 32'h5, 32'h1234, 32'hCC, 2, 32'h1234, 1'b1, 32'h0, 1'b1), -1, 1'b1);
        run_seq(mk(0, 32'h34, 32'h1234, 32'hDD, 2, 32'h1200, 1'b0, 32'h0, 1'b1), -1, 1'b1);

        // Short period with a silent sensor on the second instance: ticks are dropped and counted.
        begin
            int busy_end, pub, ovr;
            busy_end = -1;
            pub = -1;
            ovr = 0;
            enable = 1'b0;
            en2 = 1'b1;
            sens_valid2 = 1'b0;
            for (int m = 1; m <= 6000; m++) begin
                next_cycle();
                chk("ovr_cnt", 32'(overrun_cnt2), 32'(ovr));
                chk("ovr_flag", 32'(overrun2), 32'(ovr != 0));
                chk("ovr_out_valid", 32'(out_valid2), 32'(m == pub));
                if ((m % P2) == 0) begin
                    if (m <= busy_end) begin
                        if (ovr < 255) ovr++;
                    end else begin
                        busy_end = m + T + S + 3;
                        pub = busy_end;
                    end
                end
            end
            chk("ovr_saturated", 32'(overrun_cnt2), 32'd255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
